// File: rtl/stream_mux_n.sv
// -----------------------------------------------------------------------------
// stream_mux_n
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// Channel selection is either explicit (mode=0, sel picks the channel) or
// round-robin (mode=1, search starts one past the last granted channel).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   mode       : 0 = explicit select, 1 = round-robin
//   sel        : channel index used in explicit mode
//   in_data    : N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, at most one bit high
//   out_data   : registered output word
//   out_sel    : index of the channel that supplied out_data
//   out_valid  : output register holds a word
//   out_ready  : downstream accepts the output word
// -----------------------------------------------------------------------------
module stream_mux_n #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic               w_can_load;
    logic               w_gnt_vld;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic [WIDTH-1:0]   w_gnt_data;
    logic               w_xfer;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic [SEL_W-1:0]   r_rr_ptr;

    // Channel visited at search offset 'off' when the last grant was 'ptr'.
    // ptr is always < N, so ptr+1+off < 2N and one conditional wrap suffices.
    function automatic int unsigned rr_channel(input logic [SEL_W-1:0] ptr,
                                               input int unsigned      off);
        int unsigned t;
        t = 32'(ptr) + off + 1;
        return (t >= N) ? (t - N) : t;
    endfunction

    // The output register can take a new word if it is empty or draining now.
    assign w_can_load = !r_out_valid || out_ready;

    // Grant selection. Explicit mode compares sel against every legal index,
    // so an out-of-range sel simply matches nothing.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Lowest search offset with a valid channel wins.
            for (int unsigned off = 0; off < N; off++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!w_gnt_vld && rr_channel(r_rr_ptr, off) == i && in_valid[i]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data of the granted channel; only this word can reach the register.
    always_comb begin
        w_gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant always implies the granted channel is valid, so ready on that
    // channel is equivalent to a transfer. Reset blocks any acceptance.
    assign w_xfer = w_gnt_vld && w_can_load && !rst;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = w_xfer && (w_gnt_idx == SEL_W'(i));
        end
    end

    // Output stage and round-robin pointer. A load wins over a drain, which
    // gives back-to-back handoff at one word per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= SEL_W'(N - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt_idx;
            if (mode) begin
                r_rr_ptr <= w_gnt_idx;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n
// Self-checking bench for stream_mux_n: a vector table, directed sequences for
// backpressure, round-robin wrap and reset, and long random runs in both modes
// checked against a transaction-level reference model with a scoreboard.
// A second N=3 instance covers the out-of-range select case.
// -----------------------------------------------------------------------------
module tb_stream_mux_n;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;
    logic        out_ready3;

    stream_mux_n #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_n #(.WIDTH(8), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: output register contents, last round-robin grant and
    // the queue of words expected to leave the mux, in order.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t        sbq[$];
    logic        m_ov;
    logic [31:0] m_od;
    logic [1:0]  m_os;
    int          m_ptr;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_os;
        logic [31:0] e_od;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_fixed_data();
        in_data = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    endtask

    // One clock of the 4-channel DUT, with inputs already driven.
    task automatic cycle(input bit chk_rdy);
        logic [3:0] e_rdy;
        bit         found;
        bit         can;
        int         g;
        exp_t       e;
        #1;
        found = 0;
        g     = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < 4 && in_valid[sel]) begin
                found = 1;
                g     = int'(sel);
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!found && in_valid[c]) begin
                    found = 1;
                    g     = c;
                end
            end
        end
        can   = !m_ov || out_ready;
        e_rdy = (found && can && !rst) ? 4'(1 << g) : 4'b0000;
        if (chk_rdy) chk("in_ready", 64'(in_ready), 64'(e_rdy));
        if (out_valid && out_ready && !rst) begin
            chk("sb_word_expected", 64'(sbq.size() > 0), 64'(1));
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_out_data", 64'(out_data), 64'(e.d));
                chk("sb_out_sel",  64'(out_sel),  64'(e.s));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ov  = 1'b0;
            m_od  = '0;
            m_os  = '0;
            m_ptr = 3;
            sbq.delete();
        end else if (e_rdy != 4'b0000) begin
            m_ov = 1'b1;
            m_od = in_data[g*32 +: 32];
            m_os = 2'(g);
            if (mode) m_ptr = g;
            e.d = m_od;
            e.s = m_os;
            sbq.push_back(e);
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        chk("out_valid", 64'(out_valid), 64'(m_ov));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        cycle(1);
        cycle(1);
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sel",  64'(out_sel),  64'(0));
        rst      = 1'b0;
        in_valid = 4'h0;
    endtask

    task automatic check_out(input string nm, input logic ov, input logic [1:0] os,
                             input logic [31:0] od);
        chk({nm, "_valid"}, 64'(out_valid), 64'(ov));
        chk({nm, "_sel"},   64'(out_sel),   64'(os));
        chk({nm, "_data"},  64'(out_data),  64'(od));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'h0;
        out_ready  = 1'b1;
        set_fixed_data();
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_data3   = {8'h33, 8'h22, 8'h11};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        m_ov  = 1'b0;
        m_od  = '0;
        m_os  = '0;
        m_ptr = 3;
        #1;
        do_reset();
        chk("n3_rst_valid", 64'(out_valid3), 64'(0));

        // Explicit sweep, drain, then round-robin including stall and idle.
        tbl[0]  = '{1'b0, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000};
        tbl[1]  = '{1'b0, 2'd1, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        tbl[2]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 32'hA0000002};
        tbl[3]  = '{1'b0, 2'd3, 4'hF,    1'b1, 4'b1000, 1'b1, 2'd3, 32'hA0000003};
        tbl[4]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA0000003};
        tbl[5]  = '{1'b1, 2'd2, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000};
        tbl[6]  = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001};
        tbl[7]  = '{1'b1, 2'd0, 4'h0,    1'b1, 4'b0000, 1'b0, 2'd1, 32'hA0000001};
        tbl[8]  = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA0000003};
        tbl[9]  = '{1'b1, 2'd1, 4'hF,    1'b0, 4'b0000, 1'b1, 2'd3, 32'hA0000003};
        tbl[10] = '{1'b1, 2'd1, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000};
        for (int i = 0; i < 11; i++) begin
            mode      = tbl[i].mode;
            sel       = tbl[i].sel;
            in_valid  = tbl[i].vld;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            cycle(0);
            check_out($sformatf("tbl%0d_out", i), tbl[i].e_ov, tbl[i].e_os, tbl[i].e_od);
        end

        // Round-robin fairness: all valid, no bubbles.
        do_reset();
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(1);
            check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 32'hA0000000 + 32'(k % 4));
        end

        // Backpressure: word held for 5 clocks while inputs keep changing.
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'hF;
        in_data[64 +: 32] = 32'h12345678;
        cycle(1);
        check_out("bp_load", 1'b1, 2'd2, 32'h12345678);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sel     = 2'(k);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            cycle(1);
            check_out($sformatf("bp_hold%0d", k), 1'b1, 2'd2, 32'h12345678);
        end
        out_ready = 1'b1;
        sel       = 2'd1;
        in_data[32 +: 32] = 32'hCAFEF00D;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(4'b0010));
        cycle(1);
        check_out("bp_next", 1'b1, 2'd1, 32'hCAFEF00D);
        set_fixed_data();

        // Sparse round-robin with wrap past channel 3.
        do_reset();
        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle(1);
            check_out($sformatf("sparse%0d", k), 1'b1, (k % 2 == 0) ? 2'd1 : 2'd3,
                      (k % 2 == 0) ? 32'hA0000001 : 32'hA0000003);
        end

        // Reset while holding a word, then the next round-robin grant is 0.
        rst      = 1'b1;
        in_valid = 4'hF;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        cycle(1);
        check_out("midrst", 1'b0, 2'd0, 32'h0);
        rst = 1'b0;
        cycle(1);
        check_out("midrst_next", 1'b1, 2'd0, 32'hA0000000);

        // N=3 instance: load a word, then an out-of-range select drains it.
        in_valid  = 4'h0;
        mode3     = 1'b0;
        sel3      = 2'd0;
        in_valid3 = 3'b111;
        #1;
        chk("n3_sel0_ready", 64'(in_ready3), 64'(3'b001));
        cycle(1);
        chk("n3_load_valid", 64'(out_valid3), 64'(1));
        chk("n3_load_data",  64'(out_data3),  64'(8'h11));
        chk("n3_load_sel",   64'(out_sel3),   64'(0));
        sel3 = 2'd3;
        #1;
        chk("n3_oor_ready", 64'(in_ready3), 64'(0));
        cycle(1);
        chk("n3_oor_valid", 64'(out_valid3), 64'(0));
        chk("n3_oor_data",  64'(out_data3),  64'(8'h11));
        mode3     = 1'b1;
        in_valid3 = 3'b000;
        #1;
        chk("n3_idle_ready", 64'(in_ready3), 64'(0));
        cycle(1);
        chk("n3_idle_valid", 64'(out_valid3), 64'(0));

        // Random valid/ready toggling, 10000 clocks per mode.
        for (int md = 0; md < 2; md++) begin
            do_reset();
            mode = 1'(md);
            for (int k = 0; k < 10000; k++) begin
                in_valid  = 4'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                sel       = 2'($urandom_range(0, 3));
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                cycle(1);
            end
            in_valid  = 4'h0;
            out_ready = 1'b1;
            cycle(1);
            cycle(1);
            chk("rand_sb_drained", 64'(sbq.size()), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
